// File: rtl/qam16_demod.sv
// Coherent 16-QAM demapper: I/Q integrate-and-dump correlators, quadrant and
// amplitude slicer, and an MSB-first serializer for the decided 4-bit code.
// Pipeline: input capture -> multiply -> accumulate -> slice/serialize, so a
// symbol whose last sample is accepted at edge T is decided at edge T+3.
module qam16_demod #(
  parameter int unsigned SYM_LEN = 16,
  parameter int unsigned ACC_W   = 42
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [17:0]      sample_in,
  input  logic signed [15:0]      cos_ref,
  input  logic signed [15:0]      sin_ref,
  input  logic                    sample_valid,
  input  logic                    sym_sync,
  input  logic [ACC_W-1:0]        thresh,
  output logic [3:0]              sym_out,
  output logic                    sym_valid,
  output logic                    bit_out,
  output logic                    bit_valid
);

  localparam int unsigned CntW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SYM_LEN - 1);

  // Sample position bookkeeping
  logic [CntW-1:0] scnt_q;
  logic [CntW-1:0] cur_cnt;
  logic            in_start;
  logic            in_last;

  // Input capture stage
  logic                s0_valid_q;
  logic                s0_start_q;
  logic                s0_last_q;
  logic signed [17:0]  s0_sample_q;
  logic signed [15:0]  s0_cos_q;
  logic signed [15:0]  s0_sin_q;

  // Multiply stage
  logic signed [33:0]  pi_d;
  logic signed [33:0]  pq_d;
  logic signed [33:0]  pi_q;
  logic signed [33:0]  pq_q;
  logic                s1_valid_q;
  logic                s1_start_q;
  logic                s1_last_q;

  // Accumulate stage
  logic signed [ACC_W-1:0] pi_ext;
  logic signed [ACC_W-1:0] pq_ext;
  logic signed [ACC_W-1:0] acc_re_q;
  logic signed [ACC_W-1:0] acc_im_q;
  logic                    dump_q;

  // Slicer and serializer
  logic             neg_i;
  logic             neg_q;
  logic [ACC_W:0]   mag_i;
  logic [ACC_W:0]   mag_q;
  logic [3:0]       code;
  logic [3:0]       sh_q;
  logic [1:0]       bcnt_q;
  logic             busy_q;

  // Position of the incoming sample; a qualified sync restarts the symbol
  always_comb begin
    cur_cnt  = sym_sync ? '0 : scnt_q;
    in_start = (cur_cnt == '0);
    in_last  = (cur_cnt == LastCnt);
  end

  // Capture the qualified sample with its start/last flags and advance the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q      <= '0;
      s0_valid_q  <= 1'b0;
      s0_start_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_sample_q <= '0;
      s0_cos_q    <= '0;
      s0_sin_q    <= '0;
    end else begin
      s0_valid_q <= sample_valid;
      if (sample_valid) begin
        s0_sample_q <= sample_in;
        s0_cos_q    <= cos_ref;
        s0_sin_q    <= sin_ref;
        s0_start_q  <= in_start;
        s0_last_q   <= in_last;
        scnt_q      <= in_last ? '0 : cur_cnt + CntW'(1);
      end
    end
  end

  // Signed 18x16 products; the low 34 bits of a 34x34 product are exact here
  always_comb begin
    pi_d = $signed({{16{s0_sample_q[17]}}, s0_sample_q}) * $signed({{18{s0_cos_q[15]}}, s0_cos_q});
    pq_d = $signed({{16{s0_sample_q[17]}}, s0_sample_q}) * $signed({{18{s0_sin_q[15]}}, s0_sin_q});
  end

  // Register products and delay the sample flags alongside them
  always_ff @(posedge clk) begin
    if (reset) begin
      pi_q       <= '0;
      pq_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_start_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        pi_q       <= pi_d;
        pq_q       <= pq_d;
        s1_start_q <= s0_start_q;
        s1_last_q  <= s0_last_q;
      end
    end
  end

  // Sign-extend products to accumulator width
  always_comb begin
    pi_ext = {{(ACC_W-34){pi_q[33]}}, pi_q};
    pq_ext = {{(ACC_W-34){pq_q[33]}}, pq_q};
  end

  // Integrate-and-dump: a start product reloads, the last product flags the dump
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
      dump_q   <= 1'b0;
    end else begin
      dump_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        acc_re_q <= s1_start_q ? pi_ext : acc_re_q + pi_ext;
        acc_im_q <= s1_start_q ? pq_ext : acc_im_q + pq_ext;
      end
    end
  end

  // Slice: quadrant from signs, amplitude bits from magnitudes (one extra bit
  // so the most negative accumulation does not wrap)
  always_comb begin
    neg_i = acc_re_q[ACC_W-1];
    neg_q = acc_im_q[ACC_W-1];
    mag_i = neg_i ? ({1'b0, ~acc_re_q} + {{ACC_W{1'b0}}, 1'b1}) : {1'b0, acc_re_q};
    mag_q = neg_q ? ({1'b0, ~acc_im_q} + {{ACC_W{1'b0}}, 1'b1}) : {1'b0, acc_im_q};
    code  = {neg_q, neg_i ^ neg_q, (mag_q >= {1'b0, thresh}), (mag_i >= {1'b0, thresh})};
  end

  // Register the decision and shift it out MSB first; a new load restarts at MSB
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sh_q      <= '0;
      bcnt_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      sym_valid <= dump_q;
      if (dump_q) begin
        sym_out <= code;
        sh_q    <= code;
        bcnt_q  <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        sh_q    <= {sh_q[2:0], 1'b0};
        bcnt_q  <= bcnt_q + 2'd1;
        busy_q  <= (bcnt_q != 2'd3);
      end
    end
  end

  assign bit_out   = busy_q & sh_q[3];
  assign bit_valid = busy_q;

endmodule

// File: tb/tb_qam16_demod.sv
// Self-checking bench for qam16_demod: directed and randomized symbols are
// compared against a sum-of-products reference with an explicit slicer.
module tb_qam16_demod;

  localparam int unsigned SymLen = 16;
  localparam int unsigned AccW   = 42;
  localparam longint      DefTh  = 64'd6442450944;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic signed [17:0]     sample_in;
  logic signed [15:0]     cos_ref;
  logic signed [15:0]     sin_ref;
  logic                   sample_valid;
  logic                   sym_sync;
  logic [AccW-1:0]        thresh;
  logic [3:0]             sym_out;
  logic                   sym_valid;
  logic                   bit_out;
  logic                   bit_valid;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     idle_bad = 0;
  logic   mon_en = 1'b0;
  longint th = DefTh;

  int         exp_sc[$];
  int         got_sc[$];
  logic [3:0] exp_sv[$];
  logic [3:0] got_sv[$];
  int         exp_bc[$];
  int         got_bc[$];
  logic       exp_bv[$];
  logic       got_bv[$];

  qam16_demod #(.SYM_LEN(SymLen), .ACC_W(AccW)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .cos_ref(cos_ref),
    .sin_ref(sin_ref), .sample_valid(sample_valid), .sym_sync(sym_sync),
    .thresh(thresh), .sym_out(sym_out), .sym_valid(sym_valid),
    .bit_out(bit_out), .bit_valid(bit_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (sym_valid) begin
        got_sc.push_back(cyc);
        got_sv.push_back(sym_out);
      end
      if (bit_valid) begin
        got_bc.push_back(cyc);
        got_bv.push_back(bit_out);
      end
      if (!bit_valid && bit_out !== 1'b0) idle_bad++;
    end
  end

  // Reference slicer: quadrant table and |x| >= threshold
  function automatic logic [3:0] decide(input longint i, input longint q, input longint t);
    logic [1:0] quad;
    longint ai, aq;
    if (i >= 0 && q >= 0)      quad = 2'b00;
    else if (i < 0 && q >= 0)  quad = 2'b01;
    else if (i < 0)            quad = 2'b10;
    else                       quad = 2'b11;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    return {quad, (aq >= t), (ai >= t)};
  endfunction

  task automatic clear_events();
    exp_sc.delete(); got_sc.delete(); exp_sv.delete(); got_sv.delete();
    exp_bc.delete(); got_bc.delete(); exp_bv.delete(); got_bv.delete();
  endtask

  // A symbol whose last sample was taken at cycle t is decided at t+3, bits t+3..t+6
  task automatic expect_sym(input int t, input logic [3:0] code);
    exp_sc.push_back(t + 3);
    exp_sv.push_back(code);
    for (int k = 0; k < 4; k++) begin
      exp_bc.push_back(t + 3 + k);
      exp_bv.push_back(code[3-k]);
    end
  endtask

  task automatic drive(input int s, input int c, input int sn, input logic sync, output int t);
    sample_in    = 18'(s);
    cos_ref      = 16'(c);
    sin_ref      = 16'(sn);
    sym_sync     = sync;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    t            = cyc;
    sample_valid = 1'b0;
    sym_sync     = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    sample_valid = 1'b1;
    sym_sync     = 1'b1;
    sample_in    = 18'sd1000;
    cos_ref      = 16'sd2000;
    sin_ref      = 16'sd3000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sym_out !== 4'b0) begin errors++; $display("FAIL reset sym_out: got %b want 0000", sym_out); end
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset sym_valid: got %b want 0", sym_valid); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset bit_out: got %b want 0", bit_out); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset bit_valid: got %b want 0", bit_valid); end
    sample_valid = 1'b0;
    sym_sync     = 1'b0;
    reset        = 1'b0;
    idle(2);
    mon_en = 1'b1;
  endtask

  task automatic test_const(input string name, input int s, input int c, input int sn,
                            input logic [3:0] want);
    int t;
    t = 0;
    clear_events();
    thresh = 42'(th);
    for (int k = 0; k < SymLen; k++) drive(s, c, sn, 1'b0, t);
    expect_sym(t, want);
    idle(10);
    checks++;
    if (got_sc.size() != exp_sc.size() || got_bc.size() != exp_bc.size()) begin
      errors++;
      $display("FAIL %s events: got %0d strobes/%0d bits want %0d/%0d", name,
               got_sc.size(), got_bc.size(), exp_sc.size(), exp_bc.size());
    end else begin
      foreach (exp_sc[i]) begin
        checks++;
        if (got_sc[i] !== exp_sc[i] || got_sv[i] !== exp_sv[i]) begin
          errors++;
          $display("FAIL %s sym: got %b @%0d want %b @%0d", name, got_sv[i], got_sc[i], exp_sv[i], exp_sc[i]);
        end
      end
      foreach (exp_bc[i]) begin
        checks++;
        if (got_bc[i] !== exp_bc[i] || got_bv[i] !== exp_bv[i]) begin
          errors++;
          $display("FAIL %s bit %0d: got %b @%0d want %b @%0d", name, i, got_bv[i], got_bc[i], exp_bv[i], exp_bc[i]);
        end
      end
    end
  endtask

  // |x| == thresh must count as amplitude 2; zero accumulation counts as positive
  task automatic test_boundary();
    th = 64'd4294967296;
    test_const("thr_equal", 16384, 16384, 16384, 4'b0011);
    th = 64'd4294967297;
    test_const("thr_above", 16384, 16384, 16384, 4'b0000);
    th = DefTh;
    test_const("zero_pos", 0, -16384, -16384, 4'b0000);
  endtask

  task automatic test_sync_abort();
    int t, t0;
    t = 0; t0 = 0;
    clear_events();
    for (int k = 0; k < 7; k++) drive(-32767, 16384, 16384, 1'b0, t);
    for (int k = 0; k < SymLen; k++) begin
      drive(32767, 16384, 16384, (k == 0), t);
      if (k == 0) t0 = t;
    end
    expect_sym(t0 + SymLen - 1, 4'b0011);
    idle(10);
    checks++;
    if (got_sc.size() != exp_sc.size() || got_bc.size() != exp_bc.size()) begin
      errors++;
      $display("FAIL sync_abort events: got %0d strobes/%0d bits want %0d/%0d",
               got_sc.size(), got_bc.size(), exp_sc.size(), exp_bc.size());
    end else begin
      foreach (exp_sc[i]) begin
        checks++;
        if (got_sc[i] !== exp_sc[i] || got_sv[i] !== exp_sv[i]) begin
          errors++;
          $display("FAIL sync_abort sym: got %b @%0d want %b @%0d", got_sv[i], got_sc[i], exp_sv[i], exp_sc[i]);
        end
      end
    end
  endtask

  task automatic test_gap();
    int t, t0;
    t = 0; t0 = 0;
    clear_events();
    for (int k = 0; k < SymLen; k++) begin
      drive(32767, 16384, 16384, 1'b0, t);
      if (k == 0) t0 = t;
      if (k == 7) idle(5);
    end
    expect_sym(t0 + SymLen - 1 + 5, 4'b0011);
    idle(10);
    checks++;
    if (got_sc.size() != exp_sc.size() || got_bc.size() != exp_bc.size()) begin
      errors++;
      $display("FAIL gap events: got %0d strobes/%0d bits want %0d/%0d",
               got_sc.size(), got_bc.size(), exp_sc.size(), exp_bc.size());
    end else begin
      foreach (exp_sc[i]) begin
        checks++;
        if (got_sc[i] !== exp_sc[i] || got_sv[i] !== exp_sv[i]) begin
          errors++;
          $display("FAIL gap sym: got %b @%0d want %b @%0d", got_sv[i], got_sc[i], exp_sv[i], exp_sc[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, t0;
    t = 0; t0 = 0;
    clear_events();
    for (int k = 0; k < 10; k++) drive(32767, 16384, 16384, 1'b0, t);
    reset        = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    sample_valid = 1'b0;
    checks++; if (sym_out !== 4'b0) begin errors++; $display("FAIL rst_mid sym_out: got %b want 0000", sym_out); end
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL rst_mid sym_valid: got %b want 0", sym_valid); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL rst_mid bit_out: got %b want 0", bit_out); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL rst_mid bit_valid: got %b want 0", bit_valid); end
    for (int k = 0; k < SymLen; k++) begin
      drive(32767, 16384, 16384, 1'b0, t);
      if (k == 0) t0 = t;
    end
    expect_sym(t0 + SymLen - 1, 4'b0011);
    idle(10);
    checks++;
    if (got_sc.size() != exp_sc.size() || got_bc.size() != exp_bc.size()) begin
      errors++;
      $display("FAIL rst_mid events: got %0d strobes/%0d bits want %0d/%0d",
               got_sc.size(), got_bc.size(), exp_sc.size(), exp_bc.size());
    end else begin
      foreach (exp_sc[i]) begin
        checks++;
        if (got_sc[i] !== exp_sc[i] || got_sv[i] !== exp_sv[i]) begin
          errors++;
          $display("FAIL rst_mid sym: got %b @%0d want %b @%0d", got_sv[i], got_sc[i], exp_sv[i], exp_sc[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [8];
    int t, s, c, sn;
    longint mi, mq;
    logic neg_i, neg_q;
    codes = '{4'b0000, 4'b1111, 4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b0110, 4'b1001};
    t = 0;
    clear_events();
    for (int n = 0; n < 8; n++) begin
      // Build a carrier pattern that lands in the wanted quadrant/amplitudes
      neg_q = codes[n][3];
      neg_i = codes[n][3] ^ codes[n][2];
      c  = codes[n][0] ? 16384 : 8192;
      sn = codes[n][1] ? 16384 : 8192;
      if (neg_i) c = -c;
      if (neg_q) sn = -sn;
      mi = 0; mq = 0;
      for (int k = 0; k < SymLen; k++) begin
        s = int'($urandom_range(30000, 32767));
        mi += longint'(s) * longint'(c);
        mq += longint'(s) * longint'(sn);
        drive(s, c, sn, 1'b0, t);
      end
      expect_sym(t, decide(mi, mq, th));
    end
    idle(10);
    checks++;
    if (got_sc.size() != exp_sc.size() || got_bc.size() != exp_bc.size()) begin
      errors++;
      $display("FAIL b2b events: got %0d strobes/%0d bits want %0d/%0d",
               got_sc.size(), got_bc.size(), exp_sc.size(), exp_bc.size());
    end else begin
      foreach (exp_sc[i]) begin
        checks++;
        if (got_sc[i] !== exp_sc[i] || got_sv[i] !== exp_sv[i]) begin
          errors++;
          $display("FAIL b2b sym %0d: got %b @%0d want %b @%0d", i, got_sv[i], got_sc[i], exp_sv[i], exp_sc[i]);
        end
        if (i > 0) begin
          checks++;
          if (got_sc[i] - got_sc[i-1] != SymLen) begin
            errors++;
            $display("FAIL b2b spacing %0d: got %0d want %0d", i, got_sc[i] - got_sc[i-1], SymLen);
          end
        end
      end
      foreach (exp_bc[i]) begin
        checks++;
        if (got_bc[i] !== exp_bc[i] || got_bv[i] !== exp_bv[i]) begin
          errors++;
          $display("FAIL b2b bit %0d: got %b @%0d want %b @%0d", i, got_bv[i], got_bc[i], exp_bv[i], exp_bc[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int t, s, c, sn;
    longint mi, mq;
    t = 0;
    clear_events();
    th = longint'($urandom_range(0, 32'h7fff_ffff)) <<< 3;
    thresh = 42'(th);
    idle(2);
    for (int n = 0; n < 6; n++) begin
      mi = 0; mq = 0;
      for (int k = 0; k < SymLen; k++) begin
        s  = int'($signed(18'($urandom)));
        c  = int'($signed(16'($urandom)));
        sn = int'($signed(16'($urandom)));
        mi += longint'(s) * longint'(c);
        mq += longint'(s) * longint'(sn);
        drive(s, c, sn, 1'b0, t);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      expect_sym(t, decide(mi, mq, th));
    end
    idle(10);
    checks++;
    if (got_sc.size() != exp_sc.size() || got_bc.size() != exp_bc.size()) begin
      errors++;
      $display("FAIL random events: got %0d strobes/%0d bits want %0d/%0d",
               got_sc.size(), got_bc.size(), exp_sc.size(), exp_bc.size());
    end else begin
      foreach (exp_sc[i]) begin
        checks++;
        if (got_sc[i] !== exp_sc[i] || got_sv[i] !== exp_sv[i]) begin
          errors++;
          $display("FAIL random sym %0d: got %b @%0d want %b @%0d", i, got_sv[i], got_sc[i], exp_sv[i], exp_sc[i]);
        end
      end
      foreach (exp_bc[i]) begin
        checks++;
        if (got_bc[i] !== exp_bc[i] || got_bv[i] !== exp_bv[i]) begin
          errors++;
          $display("FAIL random bit %0d: got %b @%0d want %b @%0d", i, got_bv[i], got_bc[i], exp_bv[i], exp_bc[i]);
        end
      end
    end
    th = DefTh;
    thresh = 42'(th);
  endtask

  initial begin
    sample_valid = 1'b0;
    sym_sync     = 1'b0;
    sample_in    = '0;
    cos_ref      = '0;
    sin_ref      = '0;
    thresh       = 42'(DefTh);
    test_reset();
    test_const("amp1",   16384,  16384,  16384, 4'b0000);
    test_const("amp2",   32767,  16384,  16384, 4'b0011);
    test_const("quad01", 16384, -16384,  16384, 4'b0100);
    test_const("quad10", -16384, 16384,  16384, 4'b1000);
    test_const("quad11", 32767,  16384, -16384, 4'b1111);
    test_boundary();
    test_sync_abort();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_low: got %0d cycles with bit_out high while idle, want 0", idle_bad);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
